// File: rtl/fma_stager_pkg.sv
// Shared types and helpers for the FMA operand stager.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fma_stager_pkg;

  localparam int FMA_COUNT_DEF = 2;
  localparam int WIDTH_DEF     = 16;
  localparam int OPERANDS_DEF  = 3;
  localparam int DEPTH_DEF     = 2;

  // Width of a 0..depth occupancy counter.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int LEVEL_W = lvl_width(DEPTH_DEF);

  // One bundle: lane l occupies bits [l*OPERANDS*WIDTH +: OPERANDS*WIDTH].
  typedef logic [FMA_COUNT_DEF-1:0][OPERANDS_DEF*WIDTH_DEF-1:0] bundle_t;
  typedef logic [FMA_COUNT_DEF-1:0][OPERANDS_DEF-1:0]           mask_t;

  // Lowest bit of operand slot `slot` within a lane.
  function automatic int slice_lo(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/fma_operand_stager_bundle_fifo.sv
// Committed-bundle FIFO with same-edge push/pop and a head output built from registers.
// Latency: a push at edge N is visible at the head after edge N.
// Backpressure: full_o reports full; a push while full is taken only if a pop happens on the same edge.
// Ports: clk_i/rst_i clock and async active-high reset; push_i/push_dat_i write side;
//        pop_i consume head; head_vld_o/head_dat_o head; full_o; level_o occupancy.
module bundle_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2,
  parameter int LVL_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_dat_i,
  input  logic             pop_i,
  output logic             head_vld_o,
  output logic [W-1:0]     head_dat_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [LVL_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_vld_o = (cnt_q != '0);
  assign full_o     = (cnt_q == LVL_W'(DEPTH));
  assign pop_ok     = pop_i && head_vld_o;
  // When full, the slot being popped is the one the push overwrites.
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign head_dat_o = head_vld_o ? mem_q[rd_q] : '0;
  assign level_o    = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_ok) rd_q <= ptr_inc(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + LVL_W'(1);
        2'b01:   cnt_q <= cnt_q - LVL_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fma_operand_stager.sv
// Gathers per-lane FMA operands from partial slot writes and commits full bundles to a FIFO.
// Latency: last slot written at edge N -> commit at edge N+1 -> fma_out_valid after N+1.
// Backpressure: in_ready drops while a complete bundle cannot commit; writes then are dropped and set sticky overflow.
// Ports: clk_in, rst_in (async active-high); data_in/data_in_valid per-lane slot writes; in_ready;
//        fma_out/fma_out_valid/fma_out_ready head handshake; overflow; level.
// Optional: define FMA_STAGER_BROADCAST_EN to add bcast_data/bcast_valid (write one value to a slot of every lane).
module fma_operand_stager
  import fma_stager_pkg::*;
#(
  parameter int FMA_COUNT = 2,
  parameter int WIDTH     = 16,
  parameter int OPERANDS  = 3,
  parameter int DEPTH     = 2
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
`ifdef FMA_STAGER_BROADCAST_EN
  input  logic [WIDTH-1:0]                      bcast_data,
  input  logic [OPERANDS-1:0]                   bcast_valid,
`endif
  input  logic [FMA_COUNT*OPERANDS*WIDTH-1:0]   data_in,
  input  logic [FMA_COUNT*OPERANDS-1:0]         data_in_valid,
  output logic                                  in_ready,
  output logic [FMA_COUNT*OPERANDS*WIDTH-1:0]   fma_out,
  output logic [FMA_COUNT*OPERANDS-1:0]         fma_out_valid,
  input  logic                                  fma_out_ready,
  output logic                                  overflow,
  output logic [$clog2(DEPTH+1)-1:0]            level
);

  localparam int LANE_W = OPERANDS * WIDTH;
  localparam int SLOTS  = FMA_COUNT * OPERANDS;
  localparam int BUN_W  = FMA_COUNT * LANE_W;
  localparam int LVL_W  = lvl_width(DEPTH);

  logic [BUN_W-1:0] data_q, data_d;
  logic [SLOTS-1:0] mask_q, mask_d;
  logic             overflow_q, overflow_d;
  logic [SLOTS-1:0] wr_en;
  logic [BUN_W-1:0] wr_dat;
  logic             complete, fifo_full, head_vld, pop, commit;

`ifdef FMA_STAGER_BROADCAST_EN
  // Broadcast fills any slot the lane's own write leaves untouched this cycle.
  always_comb begin
    wr_en  = data_in_valid;
    wr_dat = data_in;
    for (int l = 0; l < FMA_COUNT; l++) begin
      for (int s = 0; s < OPERANDS; s++) begin
        if (bcast_valid[s] && !data_in_valid[l*OPERANDS + s]) begin
          wr_en[l*OPERANDS + s] = 1'b1;
          wr_dat[l*LANE_W + slice_lo(s, WIDTH) +: WIDTH] = bcast_data;
        end
      end
    end
  end
`else
  assign wr_en  = data_in_valid;
  assign wr_dat = data_in;
`endif

  assign complete = &mask_q;
  assign pop      = head_vld && fma_out_ready;
  assign commit   = complete && (!fifo_full || pop);
  assign in_ready = !(complete && fifo_full && !pop);

  // On a commit the masks restart from zero, so same-cycle writes start the next bundle.
  always_comb begin
    mask_d     = commit ? '0 : mask_q;
    data_d     = data_q;
    overflow_d = overflow_q || (!in_ready && (|wr_en));
    for (int l = 0; l < FMA_COUNT; l++) begin
      for (int s = 0; s < OPERANDS; s++) begin
        if (in_ready && wr_en[l*OPERANDS + s]) begin
          data_d[l*LANE_W + slice_lo(s, WIDTH) +: WIDTH] =
            wr_dat[l*LANE_W + slice_lo(s, WIDTH) +: WIDTH];
          mask_d[l*OPERANDS + s] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q     <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
    end
  end

  bundle_fifo #(
    .W     (BUN_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .push_i     (commit),
    .push_dat_i (data_q),
    .pop_i      (pop),
    .head_vld_o (head_vld),
    .head_dat_o (fma_out),
    .full_o     (fifo_full),
    .level_o    (level)
  );

  assign fma_out_valid = {SLOTS{head_vld}};
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_fma_operand_stager.sv
// Directed bench for fma_operand_stager at default parameters.
// Latency: n/a.
// Backpressure: exercised by holding fma_out_ready low.
module tb_fma_operand_stager;
  import fma_stager_pkg::*;

  logic               clk_in;
  logic               rst_in;
  bundle_t            din;
  mask_t              dv;
  logic               in_ready;
  logic [95:0]        fma_out;
  logic [5:0]         fma_out_valid;
  logic               fma_out_ready;
  logic               overflow;
  logic [LEVEL_W-1:0] level;

  int checks;
  int failures;

  fma_operand_stager #(
    .FMA_COUNT (2),
    .WIDTH     (16),
    .OPERANDS  (3),
    .DEPTH     (2)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
`ifdef FMA_STAGER_BROADCAST_EN
    .bcast_data    (16'h0000),
    .bcast_valid   (3'b000),
`endif
    .data_in       (din),
    .data_in_valid (dv),
    .in_ready      (in_ready),
    .fma_out       (fma_out),
    .fma_out_valid (fma_out_valid),
    .fma_out_ready (fma_out_ready),
    .overflow      (overflow),
    .level         (level)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Both lanes fully written, every slot of lane l holding v<l>.
  task automatic set_all(input logic [15:0] v0, input logic [15:0] v1);
    din[0] = {3{v0}};
    din[1] = {3{v1}};
    dv     = '1;
  endtask

  function automatic logic [95:0] all_of(input logic [15:0] v0, input logic [15:0] v1);
    return {{3{v1}}, {3{v0}}};
  endfunction

  initial begin
    checks        = 0;
    failures      = 0;
    rst_in        = 1'b1;
    din           = '0;
    dv            = '0;
    fma_out_ready = 1'b0;
    #12;
    check("rst_valid", 96'(fma_out_valid), 96'(0));
    check("rst_data", fma_out, 96'(0));
    check("rst_level", 96'(level), 96'(0));
    check("rst_overflow", 96'(overflow), 96'(0));
    check("rst_in_ready", 96'(in_ready), 96'(1));
    rst_in = 1'b0;

    // Single full write: valid two edges after the write edge.
    din[0] = 48'h1111_2222_3333;
    din[1] = 48'h4444_5555_6666;
    dv     = '1;
    tick();
    dv = '0;
    check("t1_not_yet_valid", 96'(fma_out_valid), 96'(0));
    tick();
    check("t1_valid", 96'(fma_out_valid), 96'h3F);
    check("t1_data", fma_out, 96'h4444_5555_6666_1111_2222_3333);
    check("t1_level", 96'(level), 96'(1));
    fma_out_ready = 1'b1;
    tick();
    fma_out_ready = 1'b0;
    check("t1_popped_level", 96'(level), 96'(0));
    check("t1_popped_valid", 96'(fma_out_valid), 96'(0));

    // Partial fill across three edges.
    din[0] = 48'h0000_0000_000A;
    din[1] = 48'h0007_0008_0009;
    dv     = 6'b111_001;
    tick();
    din[0] = 48'h0000_000B_0000;
    dv     = 6'b000_010;
    tick();
    check("t2_partial_valid", 96'(fma_out_valid), 96'(0));
    din[0] = 48'h000C_0000_0000;
    dv     = 6'b000_100;
    tick();
    dv = '0;
    check("t2_complete_not_out", 96'(fma_out_valid), 96'(0));
    tick();
    check("t2_valid", 96'(fma_out_valid), 96'h3F);
    check("t2_data", fma_out, 96'h0007_0008_0009_000C_000B_000A);
    fma_out_ready = 1'b1;
    tick();
    fma_out_ready = 1'b0;

    // Overwrite of an already-filled slot before completion.
    din[0] = 48'h0000_1234_0001;
    din[1] = 48'hAAAA_BBBB_CCCC;
    dv     = 6'b111_011;
    tick();
    din[0] = 48'h0000_5678_0000;
    dv     = 6'b000_010;
    tick();
    din[0] = 48'h0003_0000_0000;
    dv     = 6'b000_100;
    tick();
    dv = '0;
    tick();
    check("t4_valid", 96'(fma_out_valid), 96'h3F);
    check("t4_data", fma_out, 96'hAAAA_BBBB_CCCC_0003_5678_0001);
    fma_out_ready = 1'b1;
    tick();
    fma_out_ready = 1'b0;

    // Write on the commit edge belongs to the next bundle.
    din[0] = 48'h0101_0202_0303;
    din[1] = 48'h0404_0505_0606;
    dv     = '1;
    tick();
    din[0] = 48'h0000_0000_00FF;
    dv     = 6'b000_001;
    tick();
    dv = '0;
    check("t5_first_data", fma_out, 96'h0404_0505_0606_0101_0202_0303);
    check("t5_first_level", 96'(level), 96'(1));
    fma_out_ready = 1'b1;
    tick();
    fma_out_ready = 1'b0;
    tick();
    check("t5_next_incomplete", 96'(level), 96'(0));
    din[0] = 48'h0003_0002_0000;
    din[1] = 48'h0004_0005_0006;
    dv     = 6'b111_110;
    tick();
    dv = '0;
    tick();
    check("t5_next_valid", 96'(fma_out_valid), 96'h3F);
    check("t5_next_data", fma_out, 96'h0004_0005_0006_0003_0002_00FF);
    fma_out_ready = 1'b1;
    tick();
    fma_out_ready = 1'b0;

    // Backpressure with a full FIFO and a complete fill buffer.
    set_all(16'hB100, 16'hB101);
    tick();
    set_all(16'hB200, 16'hB201);
    tick();
    set_all(16'hB300, 16'hB301);
    tick();
    dv = '0;
    check("t3_level_full", 96'(level), 96'(2));
    check("t3_in_ready_low", 96'(in_ready), 96'(0));
    check("t3_no_overflow_yet", 96'(overflow), 96'(0));
    set_all(16'hB400, 16'hB401);
    tick();
    dv = '0;
    check("t3_overflow", 96'(overflow), 96'(1));
    check("t3_level_held", 96'(level), 96'(2));
    check("t3_head_b1", fma_out, all_of(16'hB100, 16'hB101));
    fma_out_ready = 1'b1;
    #1;
    check("t3_in_ready_on_pop", 96'(in_ready), 96'(1));
    tick();
    fma_out_ready = 1'b0;
    check("t3_level_push_pop", 96'(level), 96'(2));
    check("t3_head_b2", fma_out, all_of(16'hB200, 16'hB201));
    fma_out_ready = 1'b1;
    tick();
    check("t3_head_b3", fma_out, all_of(16'hB300, 16'hB301));
    check("t3_level_one", 96'(level), 96'(1));
    tick();
    fma_out_ready = 1'b0;
    check("t3_drained_level", 96'(level), 96'(0));
    check("t3_b4_dropped", 96'(fma_out_valid), 96'(0));
    check("t3_overflow_sticky", 96'(overflow), 96'(1));

    // Asynchronous reset between edges with two bundles held.
    set_all(16'hC100, 16'hC101);
    tick();
    set_all(16'hC200, 16'hC201);
    tick();
    dv = '0;
    tick();
    check("t6_level_before", 96'(level), 96'(2));
    #2;
    rst_in = 1'b1;
    #1;
    check("t6_async_valid", 96'(fma_out_valid), 96'(0));
    check("t6_async_level", 96'(level), 96'(0));
    check("t6_async_overflow", 96'(overflow), 96'(0));
    check("t6_async_data", fma_out, 96'(0));
    check("t6_async_in_ready", 96'(in_ready), 96'(1));
    #1;
    rst_in = 1'b0;
    set_all(16'hD100, 16'hD101);
    tick();
    dv = '0;
    tick();
    check("t6_recover_valid", 96'(fma_out_valid), 96'h3F);
    check("t6_recover_data", fma_out, all_of(16'hD100, 16'hD101));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
